pmod_als_spi_responder: RTL and testbench

Responder side of the PMOD ALS SPI link. It emulates the ambient-light sensor ADC that the SPI master interface polls, so the full sensor path (SPI master, control FSM, BCD/ASCII conversion, UART, 7-segment) can be run in simulation and in loopback on the board without the physical PMOD. It oversamples the master's cs/sclk on the local clock and shifts out a 16-bit ADC frame carrying an 8-bit light value on MISO.

---
 rtl/pmod_als_spi_responder.sv | 186 ++++++++++++++++++
 tb/tb_pmod_als_spi_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_als_spi_responder.sv
// PMOD ALS responder: emulates the light-sensor ADC frame (3 zeros, 8-bit sample,
// 5 zeros) on MISO so the SPI master path can run without the physical PMOD.
module pmod_als_spi_responder #(
    parameter int unsigned LEAD_ZEROS = 3,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FRAME_BITS = 16,
    parameter bit          CPOL       = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 sclk_i,
    output logic                 miso_o,
    output logic                 miso_oe_o,
    input  logic [DATA_BITS-1:0] light_i,
    output logic [DATA_BITS-1:0] sample_o,
    output logic                 frame_done_o,
    output logic                 frame_err_o,
    output logic [15:0]          frame_cnt_o
);

    localparam int unsigned TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
    localparam int unsigned EDGE_W      = 5;
    localparam int unsigned CNT_W       = 16;
    localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;
    localparam logic [EDGE_W-1:0] EDGE_FULL = EDGE_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_END    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_cs_meta, r_cs_sync, r_cs_d;
    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic [1:0] r_warm;

    logic [FRAME_BITS-1:0] r_shreg,  w_shreg_nxt;
    logic [EDGE_W-1:0]     r_edge_cnt, w_edge_cnt_nxt;
    logic [DATA_BITS-1:0]  r_sample, w_sample_nxt;
    logic [CNT_W-1:0]      r_frame_cnt, w_frame_cnt_nxt;
    logic r_miso, w_miso_nxt;
    logic r_oe,   w_oe_nxt;
    logic r_done, w_done_nxt;
    logic r_err,  w_err_nxt;

    logic w_cs_fall, w_cs_rise;
    logic w_sclk_rise, w_sclk_fall;
    logic w_sample_edge, w_shift_edge;
    logic w_armed;
    logic [FRAME_BITS-1:0] w_load;

    // Synchronize cs/sclk into clk_i and keep one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_d      <= 1'b1;
            r_sclk_meta <= CPOL;
            r_sclk_sync <= CPOL;
            r_sclk_d    <= CPOL;
        end else begin
            r_cs_meta   <= cs_i;
            r_cs_sync   <= r_cs_meta;
            r_cs_d      <= r_cs_sync;
            r_sclk_meta <= sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
        end
    end

    // Block frame starts until the reset-high cs chain has drained, so a cs
    // already low at reset release is not mistaken for a falling edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    assign w_armed       = (r_warm == 2'd3);
    assign w_cs_fall     = r_cs_d & ~r_cs_sync;
    assign w_cs_rise     = ~r_cs_d & r_cs_sync;
    assign w_sclk_rise   = ~r_sclk_d & r_sclk_sync;
    assign w_sclk_fall   = r_sclk_d & ~r_sclk_sync;
    assign w_sample_edge = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_shift_edge  = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_load        = FRAME_BITS'(light_i) << TRAIL_ZEROS;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next datapath values; cs edges take priority over sclk edges.
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_edge_cnt_nxt  = r_edge_cnt;
        w_sample_nxt    = r_sample;
        w_frame_cnt_nxt = r_frame_cnt;
        w_miso_nxt      = r_miso;
        w_oe_nxt        = r_oe;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall && w_armed) begin
                    w_state_nxt    = S_ACTIVE;
                    w_shreg_nxt    = w_load;
                    w_sample_nxt   = light_i;
                    w_miso_nxt     = w_load[FRAME_BITS-1];
                    w_oe_nxt       = 1'b1;
                    w_edge_cnt_nxt = '0;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_END;
                    w_oe_nxt    = 1'b0;
                    w_miso_nxt  = 1'b0;
                    if (r_edge_cnt == EDGE_FULL) begin
                        w_done_nxt      = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_sample_edge) begin
                    if (r_edge_cnt != EDGE_MAX) begin
                        w_edge_cnt_nxt = r_edge_cnt + 5'd1;
                    end
                end else if (w_shift_edge) begin
                    w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
                    w_miso_nxt  = r_shreg[FRAME_BITS-2];
                end
            end
            S_END: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_oe_nxt    = 1'b0;
                w_miso_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shreg     <= '0;
            r_edge_cnt  <= '0;
            r_sample    <= '0;
            r_frame_cnt <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_shreg     <= w_shreg_nxt;
            r_edge_cnt  <= w_edge_cnt_nxt;
            r_sample    <= w_sample_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_miso      <= w_miso_nxt;
            r_oe        <= w_oe_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign miso_o       = r_miso;
    assign miso_oe_o    = r_oe;
    assign sample_o     = r_sample;
    assign frame_done_o = r_done;
    assign frame_err_o  = r_err;
    assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// Directed bench for the PMOD ALS responder: acts as a mode-0 SPI master.
module tb_pmod_als_spi_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cs_i;
    logic        sclk_i;
    logic        miso_o;
    logic        miso_oe_o;
    logic [7:0]  light_i;
    logic [7:0]  sample_o;
    logic        frame_done_o;
    logic        frame_err_o;
    logic [15:0] frame_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err  = 0;
    bit both_seen = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    pmod_als_spi_responder dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cs_i        (cs_i),
        .sclk_i      (sclk_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .light_i     (light_i),
        .sample_o    (sample_o),
        .frame_done_o(frame_done_o),
        .frame_err_o (frame_err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Count status pulses, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (frame_done_o) n_done++;
        if (frame_err_o) n_err++;
        if (frame_done_o && frame_err_o) both_seen = 1'b1;
    end

    // Master: cs low, nbits sclk periods (half-period 8 clk), sample MISO on rise.
    task automatic run_frame(input int nbits, input int chg_at, input logic [7:0] chg_val,
                             output logic [15:0] word, output logic oe_mid, output logic oe_after);
        word = 16'h0;
        oe_mid = 1'b0;
        @(negedge clk_i);
        cs_i = 1'b0;
        repeat (8) @(negedge clk_i);
        oe_mid = miso_oe_o;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) light_i = chg_val;
            word = {word[14:0], miso_o};
            sclk_i = 1'b1;
            repeat (8) @(negedge clk_i);
            sclk_i = 1'b0;
            repeat (8) @(negedge clk_i);
        end
        cs_i = 1'b1;
        repeat (4) @(negedge clk_i);
        oe_after = miso_oe_o;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; cs_i = 1'b0; sclk_i = 1'b0; light_i = 8'h00;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (miso_o !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", miso_o); end
        n_cmp++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", miso_oe_o); end
        n_cmp++; if (sample_o !== 8'h00) begin n_fail++; $display("FAIL reset_sample got %h want 00", sample_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err_o); end
        n_cmp++; if (frame_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", frame_cnt_o); end
        rst_i = 1'b1;
        repeat (20) @(negedge clk_i);
        n_cmp++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL cs_low_release_oe got %b want 0", miso_oe_o); end
        n_cmp++; if ((n_done + n_err) !== 0) begin n_fail++; $display("FAIL cs_low_release_pulses got %0d want 0", n_done + n_err); end
        cs_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_basic();
        logic [15:0] w; logic om, oa; int d0, e0;
        d0 = n_done; e0 = n_err;
        light_i = 8'hA5;
        run_frame(16, -1, 8'h00, w, om, oa);
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (w !== 16'h14A0) begin n_fail++; $display("FAIL basic_word got %h want 14a0", w); end
        n_cmp++; if (om !== 1'b1) begin n_fail++; $display("FAIL basic_oe_active got %b want 1", om); end
        n_cmp++; if (oa !== 1'b0) begin n_fail++; $display("FAIL basic_oe_after got %b want 0", oa); end
        n_cmp++; if (sample_o !== 8'hA5) begin n_fail++; $display("FAIL basic_sample got %h want a5", sample_o); end
        n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
        n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL basic_err got %0d want 0", n_err - e0); end
        n_cmp++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL basic_cnt got %h want %h", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w; logic om, oa; int d0;
        d0 = n_done;
        light_i = 8'hFF;
        run_frame(16, -1, 8'h00, w, om, oa);
        n_cmp++; if (w !== 16'h1FE0) begin n_fail++; $display("FAIL b2b_ff_word got %h want 1fe0", w); end
        light_i = 8'h00;
        run_frame(16, 8, 8'h3C, w, om, oa);
        n_cmp++; if (w !== 16'h0000) begin n_fail++; $display("FAIL b2b_00_word got %h want 0000", w); end
        n_cmp++; if (sample_o !== 8'h00) begin n_fail++; $display("FAIL b2b_00_sample got %h want 00", sample_o); end
        run_frame(16, -1, 8'h00, w, om, oa);
        n_cmp++; if (w !== 16'h0780) begin n_fail++; $display("FAIL b2b_3c_word got %h want 0780", w); end
        n_cmp++; if (sample_o !== 8'h3C) begin n_fail++; $display("FAIL b2b_3c_sample got %h want 3c", sample_o); end
        exp_cnt = exp_cnt + 16'd3;
        n_cmp++; if (n_done - d0 !== 3) begin n_fail++; $display("FAIL b2b_done got %0d want 3", n_done - d0); end
        n_cmp++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got %h want %h", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_short_frame();
        logic [15:0] w; logic om, oa; int d0, e0;
        d0 = n_done; e0 = n_err;
        light_i = 8'h42;
        run_frame(10, -1, 8'h00, w, om, oa);
        n_cmp++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL short_err got %0d want 1", n_err - e0); end
        n_cmp++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL short_done got %0d want 0", n_done - d0); end
        n_cmp++; if (oa !== 1'b0) begin n_fail++; $display("FAIL short_oe_after got %b want 0", oa); end
        n_cmp++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL short_cnt got %h want %h", frame_cnt_o, exp_cnt); end
        light_i = 8'h81;
        run_frame(16, -1, 8'h00, w, om, oa);
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (w !== 16'h1020) begin n_fail++; $display("FAIL short_next_word got %h want 1020", w); end
        n_cmp++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL short_next_cnt got %h want %h", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w; logic om, oa; bit oe_seen; int d0, e0;
        oe_seen = 1'b0;
        light_i = 8'h5A;
        @(negedge clk_i);
        cs_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            sclk_i = 1'b1; repeat (8) @(negedge clk_i);
            sclk_i = 1'b0; repeat (8) @(negedge clk_i);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL midrst_oe got %b want 0", miso_oe_o); end
        n_cmp++; if (sample_o !== 8'h00) begin n_fail++; $display("FAIL midrst_sample got %h want 00", sample_o); end
        n_cmp++; if (frame_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_cnt got %h want 0000", frame_cnt_o); end
        exp_cnt = 16'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 13; i++) begin
            sclk_i = 1'b1;
            repeat (8) begin @(negedge clk_i); if (miso_oe_o) oe_seen = 1'b1; end
            sclk_i = 1'b0;
            repeat (8) begin @(negedge clk_i); if (miso_oe_o) oe_seen = 1'b1; end
        end
        cs_i = 1'b1;
        repeat (12) @(negedge clk_i);
        n_cmp++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_ignored_oe got %b want 0", oe_seen); end
        n_cmp++; if ((n_done - d0) + (n_err - e0) !== 0) begin n_fail++; $display("FAIL midrst_pulses got %0d want 0", (n_done - d0) + (n_err - e0)); end
        light_i = 8'hA5;
        run_frame(16, -1, 8'h00, w, om, oa);
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (w !== 16'h14A0) begin n_fail++; $display("FAIL midrst_next_word got %h want 14a0", w); end
        n_cmp++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL midrst_next_cnt got %h want %h", frame_cnt_o, exp_cnt); end
    endtask

    task automatic test_count_wrap();
        logic [15:0] w; logic om, oa; int d0;
        @(negedge clk_i);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk_i);
        release dut.r_frame_cnt;
        d0 = n_done;
        light_i = 8'h81;
        run_frame(16, -1, 8'h00, w, om, oa);
        n_cmp++; if (frame_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt got %h want 0000", frame_cnt_o); end
        n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL wrap_done got %0d want 1", n_done - d0); end
        n_cmp++; if (w !== 16'h1020) begin n_fail++; $display("FAIL wrap_word got %h want 1020", w); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_short_frame();
        test_reset_mid_frame();
        test_count_wrap();
        n_cmp++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL done_err_overlap got %b want 0", both_seen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
